// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single line-wide memory port.
// Default: D-priority with an I starvation bound; define MEM_ARB_RR_EN for strict round-robin.
module mem_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    // state  | meaning
    // IDLE   | arbitrate on current requests
    // GNT_I  | I transaction on memory port, waiting for mem_ready
    // GNT_D  | D transaction on memory port, waiting for mem_ready
    // RESP   | one-cycle ready pulse to the owner (owner_q)
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;     // 1 = D owns the transaction
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic req_i, req_d, grant_i, grant_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    logic rr_q, rr_d;                          // 0 = I preferred on contention

    assign grant_i = (state_q == IDLE) && req_i && (!req_d || !rr_q);
    assign grant_d = (state_q == IDLE) && req_d && !grant_i;

    always_comb begin
        rr_d = rr_q;
        if (grant_i || grant_d)
            rr_d = ~rr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`else
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    logic [3:0] starve_q, starve_d;

    assign grant_i = (state_q == IDLE) && req_i && (!req_d || starve_q == LIM);
    assign grant_d = (state_q == IDLE) && req_d && !grant_i;

    always_comb begin
        starve_d = starve_q;
        if (grant_i)
            starve_d = 4'd0;
        else if (grant_d) begin
            if (!req_i)
                starve_d = 4'd0;
            else if (starve_q != LIM)
                starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= 4'd0;
        else     starve_q <= starve_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i)      state_d = GNT_I;
                else if (grant_d) state_d = GNT_D;
            end
            GNT_I, GNT_D: if (mem_ready) state_d = RESP;
            RESP:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        i_ready = (state_q == RESP) && !owner_q;
        d_ready = (state_q == RESP) &&  owner_q;
    end

    // Request fields are captured on the grant edge; write wins if both op bits are set.
    always_comb begin
        owner_d     = owner_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        if (grant_i) begin
            owner_d     = 1'b0;
            mem_read_d  = !i_write;
            mem_write_d = i_write;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
        end else if (grant_d) begin
            owner_d     = 1'b1;
            mem_read_d  = !d_write;
            mem_write_d = d_write;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (mem_ready && (state_q == GNT_I || state_q == GNT_D)) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (state_q == GNT_D) d_rdata_d = mem_rdata;
            else                  i_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone/contended requests, starvation bound
// (or round-robin when MEM_ARB_RR_EN is defined), stray mem_ready, mid-transaction reset.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    int nvec = 0;
    int nerr = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a grant edge; completes the transaction and leaves the DUT in IDLE.
    task automatic txn(input string tag, input bit to_d, input logic [AW-1:0] exp_addr,
                       input bit exp_wr, input logic [DW-1:0] exp_wd,
                       input logic [DW-1:0] rd, input bit drop);
        chk({tag, "_addr"}, DW'(mem_addr), DW'(exp_addr));
        chk({tag, "_rd"},   DW'(mem_read), DW'(!exp_wr));
        chk({tag, "_wr"},   DW'(mem_write), DW'(exp_wr));
        if (exp_wr) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        tick();
        mem_rdata = rd;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk({tag, "_iready"}, DW'(i_ready), DW'(!to_d));
        chk({tag, "_dready"}, DW'(d_ready), DW'(to_d));
        chk({tag, "_rdata"}, to_d ? d_rdata : i_rdata, rd);
        chk({tag, "_strobe_off"}, DW'({mem_read, mem_write}), '0);
        if (drop) begin
            if (to_d) begin d_read = 1'b0; d_write = 1'b0; end
            else      begin i_read = 1'b0; i_write = 1'b0; end
        end
        tick();
        chk({tag, "_ready_off"}, DW'({i_ready, d_ready}), '0);
    endtask

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] dw;
        a5 = {16{8'hA5}};
        dw = {4{32'hDEAD_BEEF}};
        rst = 1'b1;
        {i_read, i_write, d_read, d_write, mem_ready} = '0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        chk("reset_outs", DW'({i_ready, d_ready, mem_read, mem_write}), '0);
        chk("reset_addr", DW'(mem_addr), '0);
        chk("reset_rdata", i_rdata | d_rdata | mem_wdata, '0);
        rst = 1'b0;
        tick();

        // Lone I read, memory answers 3 cycles after the request
        i_read = 1'b1; i_addr = 28'h0000123;
        tick();
        chk("t2_mem_read", DW'(mem_read), 1);
        chk("t2_mem_addr", DW'(mem_addr), DW'(28'h0000123));
        i_addr = 28'h0FFFFFF;
        d_read = 1'b1; d_addr = 28'h0000777;
        tick();
        chk("t2_addr_held", DW'(mem_addr), DW'(28'h0000123));
        d_read = 1'b0;
        tick();
        mem_rdata = a5; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("t2_i_ready", DW'(i_ready), 1);
        chk("t2_d_ready", DW'(d_ready), 0);
        chk("t2_i_rdata", i_rdata, a5);
        i_read = 1'b0;
        tick();
        chk("t2_ready_off", DW'({i_ready, d_ready}), 0);
        tick();
        chk("t2_idle_no_grant", DW'({mem_read, mem_write}), 0);
        chk("t2_rdata_hold", i_rdata, a5);

        // Stray mem_ready in IDLE
        mem_ready = 1'b1; mem_rdata = dw;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("t6_no_ready", DW'({i_ready, d_ready}), 0);
        tick();
        chk("t6_no_ready2", DW'({i_ready, d_ready, mem_read, mem_write}), 0);
        chk("t6_rdata_kept", i_rdata | d_rdata, a5);

        // Simultaneous I read and D write: D first, I after RESP+IDLE
        i_read = 1'b1; i_addr = 28'h0000200;
        d_write = 1'b1; d_addr = 28'h0000040; d_wdata = dw;
        tick();
        txn("t3_d", 1'b1, 28'h0000040, 1'b1, dw, 128'h1111, 1'b1);
        tick();
        txn("t3_i", 1'b0, 28'h0000200, 1'b0, '0, 128'h2222, 1'b1);

        // Illegal read+write from D is handled as a write
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h0000050; d_wdata = ~dw;
        tick();
        txn("rw_as_write", 1'b1, 28'h0000050, 1'b1, ~dw, 128'h3333, 1'b1);

        // Fresh reset so the arbitration history starts clean
        rst = 1'b1; tick(); rst = 1'b0; tick();
        i_read = 1'b1; i_addr = 28'h0000AAA;
        d_read = 1'b1; d_addr = 28'h0000BBB;
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            txn($sformatf("rr_%0d", k), k[0], k[0] ? 28'h0000BBB : 28'h0000AAA,
                1'b0, '0, DW'(k + 16), 1'b0);
        end
`else
        for (int k = 0; k < 6; k++) begin
            bit is_i;
            is_i = (k == 4);
            tick();
            txn($sformatf("starve_%0d", k), !is_i, is_i ? 28'h0000AAA : 28'h0000BBB,
                1'b0, '0, DW'(k + 16), 1'b0);
        end
`endif
        i_read = 1'b0; d_read = 1'b0;
        tick();

        // Reset in the middle of a D grant
        d_read = 1'b1; d_addr = 28'h0000099;
        tick();
        chk("t1_granted", DW'(mem_read), 1);
        rst = 1'b1;
        #1;
        chk("t1_async_clear", DW'({mem_read, mem_write, d_ready, i_ready}), 0);
        d_read = 1'b0;
        tick();
        rst = 1'b0;
        chk("t1_addr_clear", DW'(mem_addr), 0);
        mem_ready = 1'b1; mem_rdata = a5;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_no_dready_%0d", k), DW'({d_ready, i_ready, mem_read}), 0);
            tick();
        end
        chk("t1_rdata_cleared", d_rdata, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
